// File: rtl/divisor_pkg.sv
// Shared types and helpers for the parametrised serial divider.
package divisor_pkg;

   // Default operand/result width used by the top when no override is given.
   localparam int DIV_WIDTH_DEF = 16;

   // Widest operand the helpers below accept; narrower values are extended first.
   localparam int DIV_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Two's complement negate; callers truncate the result back to their width.
   function automatic logic [DIV_MAX_W-1:0] twos_neg(input logic [DIV_MAX_W-1:0] v);
      return ~v + 1'b1;
   endfunction

   // Magnitude of a sign-extended value. The most-negative value of any narrower
   // width maps onto its own bit pattern once truncated, which the datapath relies on.
   function automatic logic [DIV_MAX_W-1:0] twos_abs(input logic [DIV_MAX_W-1:0] v);
      return v[DIV_MAX_W-1] ? twos_neg(v) : v;
   endfunction

endpackage

// File: rtl/divisor_iter_core.sv
// Unsigned restoring shift/subtract core: one quotient bit per step.
// The dividend register doubles as the quotient register: dividend bits leave
// at the top while quotient bits enter at the bottom.
module divisor_iter_core
   import divisor_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_last
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quot;
   logic [CNT_W-1:0] r_cnt;

   // Partial remainder after the shift is WIDTH+1 bits wide.
   logic [WIDTH:0]   w_trial;
   logic             w_fits;
   logic [WIDTH-1:0] w_diff;

   assign w_trial = {r_rem, r_quot[WIDTH-1]};
   assign w_fits  = (w_trial >= {1'b0, i_divisor});
   // A fitting difference is always below the divisor, so WIDTH bits hold it.
   assign w_diff  = WIDTH'(w_trial - {1'b0, i_divisor});

   assign o_quot = r_quot;
   assign o_rem  = r_rem;
   assign o_last = (r_cnt == '0);

   // Load operands, then shift/trial-subtract once per step with restore on borrow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rem  <= '0;
         r_quot <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_rem  <= '0;
         r_quot <= i_dividend;
         r_cnt  <= CNT_W'(WIDTH - 1);
      end else if (i_step) begin
         r_rem  <= w_fits ? w_diff : w_trial[WIDTH-1:0];
         r_quot <= {r_quot[WIDTH-2:0], w_fits};
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/divisor_param.sv
// Parametrised serial divider with signed/unsigned mode, Start/Done level
// handshake, divide-by-zero and signed-overflow flags.
module divisor_param
   import divisor_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RSTa,
   input  logic             Start,
   input  logic             Signed_Mode,
   input  logic [WIDTH-1:0] Num,
   input  logic [WIDTH-1:0] Den,
   output logic [WIDTH-1:0] Coc,
   output logic [WIDTH-1:0] Res,
   output logic             Done,
   output logic             Busy,
   output logic             DivZero,
   output logic             Ovf
);

   div_state_t r_state;
   div_state_t w_state_nxt;

   logic             r_smode;
   logic             r_sn;
   logic             r_sd;
   logic             r_ovf_pend;
   logic [WIDTH-1:0] r_den_mag;
   logic [WIDTH-1:0] r_coc;
   logic [WIDTH-1:0] r_res;
   logic             r_done;
   logic             r_divzero;
   logic             r_ovf;

   logic             w_sample;
   logic             w_den_zero;
   logic             w_ovf_det;
   logic             w_core_load;
   logic             w_core_step;
   logic             w_core_last;
   logic [WIDTH-1:0] w_num_mag;
   logic [WIDTH-1:0] w_den_mag;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_coc_fix;
   logic [WIDTH-1:0] w_res_fix;

   assign w_sample   = (r_state == IDLE) && Start;
   assign w_den_zero = (Den == '0);
   // Only most-negative / -1 overflows; the magnitude datapath already wraps it correctly.
   assign w_ovf_det  = Signed_Mode && (Num == {1'b1, {(WIDTH-1){1'b0}}}) && (Den == '1);

   assign w_num_mag = Signed_Mode ? WIDTH'(twos_abs(DIV_MAX_W'($signed(Num)))) : Num;
   assign w_den_mag = Signed_Mode ? WIDTH'(twos_abs(DIV_MAX_W'($signed(Den)))) : Den;

   assign w_core_load = w_sample && !w_den_zero;
   assign w_core_step = (r_state == ITER);

   // Truncating division: quotient sign is sN xor sD, remainder follows the dividend.
   assign w_coc_fix = (r_smode && (r_sn ^ r_sd)) ? WIDTH'(twos_neg(DIV_MAX_W'(w_quot))) : w_quot;
   assign w_res_fix = (r_smode && r_sn)          ? WIDTH'(twos_neg(DIV_MAX_W'(w_rem)))  : w_rem;

   assign Coc     = r_coc;
   assign Res     = r_res;
   assign Done    = r_done;
   assign Busy    = (r_state == ITER) || (r_state == FIX);
   assign DivZero = r_divzero;
   assign Ovf     = r_ovf;

   divisor_iter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .i_clk      (CLK),
      .i_rst_n    (RSTa),
      .i_load     (w_core_load),
      .i_step     (w_core_step),
      .i_dividend (w_num_mag),
      .i_divisor  (r_den_mag),
      .o_quot     (w_quot),
      .o_rem      (w_rem),
      .o_last     (w_core_last)
   );

   // State register.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; DONE is held for at least one edge so Done is always seen.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_state_nxt = w_den_zero ? DONE : ITER;
            end
         end
         ITER: begin
            if (w_core_last) begin
               w_state_nxt = FIX;
            end
         end
         FIX: begin
            w_state_nxt = DONE;
         end
         DONE: begin
            if (r_done && !Start) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture at the sampling edge, result/flag registers, registered Done.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         r_smode    <= 1'b0;
         r_sn       <= 1'b0;
         r_sd       <= 1'b0;
         r_ovf_pend <= 1'b0;
         r_den_mag  <= '0;
         r_coc      <= '0;
         r_res      <= '0;
         r_done     <= 1'b0;
         r_divzero  <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_done <= (r_state == DONE) && (w_state_nxt == DONE);
         if (w_sample) begin
            r_smode    <= Signed_Mode;
            r_sn       <= Num[WIDTH-1];
            r_sd       <= Den[WIDTH-1];
            r_den_mag  <= w_den_mag;
            r_ovf_pend <= w_ovf_det;
            r_ovf      <= 1'b0;
            r_divzero  <= w_den_zero;
            if (w_den_zero) begin
               r_coc <= '1;
               r_res <= Num;
            end
         end else if (r_state == FIX) begin
            r_coc <= w_coc_fix;
            r_res <= w_res_fix;
            r_ovf <= r_ovf_pend;
         end
      end
   end

endmodule

// File: tb/tb_divisor_param.sv
// Self-checking bench for divisor_param: directed cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_divisor_param;

   logic        CLK = 1'b0;
   logic        RSTa;
   logic        Start;
   logic        Signed_Mode;
   logic [15:0] Num;
   logic [15:0] Den;
   logic [15:0] Coc;
   logic [15:0] Res;
   logic        Done;
   logic        Busy;
   logic        DivZero;
   logic        Ovf;

   logic        Start8;
   logic        Smode8;
   logic [7:0]  Num8;
   logic [7:0]  Den8;
   logic [7:0]  Coc8;
   logic [7:0]  Res8;
   logic        Done8;
   logic        Busy8;
   logic        DivZero8;
   logic        Ovf8;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   int busy_cnt;
   bit tmo;

   always #5 CLK = ~CLK;

   divisor_param #(.WIDTH(16)) dut16 (
      .CLK(CLK), .RSTa(RSTa), .Start(Start), .Signed_Mode(Signed_Mode),
      .Num(Num), .Den(Den), .Coc(Coc), .Res(Res), .Done(Done), .Busy(Busy),
      .DivZero(DivZero), .Ovf(Ovf)
   );

   divisor_param #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RSTa(RSTa), .Start(Start8), .Signed_Mode(Smode8),
      .Num(Num8), .Den(Den8), .Coc(Coc8), .Res(Res8), .Done(Done8), .Busy(Busy8),
      .DivZero(DivZero8), .Ovf(Ovf8)
   );

   // Reference: C-style truncating division on plain integers.
   function automatic void ref_div(input int w, input logic [15:0] num, input logic [15:0] den,
                                   input bit sm, output logic [15:0] q, output logic [15:0] r,
                                   output bit dz, output bit ovf);
      longint n, d, mask;
      mask = (longint'(1) << w) - 1;
      n = longint'(num) & mask;
      d = longint'(den) & mask;
      if (sm && num[w-1]) n = n - (longint'(1) << w);
      if (sm && den[w-1]) d = d - (longint'(1) << w);
      if (d == 0) begin
         q = 16'(mask); r = 16'(n & mask); dz = 1'b1; ovf = 1'b0;
      end else begin
         q = 16'((n / d) & mask);
         r = 16'((n % d) & mask);
         dz = 1'b0;
         ovf = sm && (n == -(longint'(1) << (w - 1))) && (d == -1);
      end
   endfunction

   // Drive one 16-bit request and wait (bounded) for Done; Start stays high.
   task automatic do_op(input logic [15:0] n, input logic [15:0] d, input bit sm);
      @(negedge CLK);
      Num = n; Den = d; Signed_Mode = sm; Start = 1'b1;
      @(posedge CLK); #1;
      busy_cnt = Busy ? 1 : 0;
      lat = 0;
      Num = 16'($urandom); Den = 16'($urandom); Signed_Mode = 1'($urandom);
      do begin
         @(posedge CLK); #1;
         lat++;
         if (Busy && !Done) busy_cnt++;
      end while (!Done && lat < 60);
      tmo = !Done;
   endtask

   task automatic release_start;
      @(negedge CLK);
      Start = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset;
      RSTa = 1'b0; Start = 1'b0; Signed_Mode = 1'b0; Num = '0; Den = '0;
      Start8 = 1'b0; Smode8 = 1'b0; Num8 = '0; Den8 = '0;
      repeat (3) @(posedge CLK);
      #1;
      n_tests++;
      if ({Coc, Res, Done, Busy, DivZero, Ovf} !== 36'd0 ||
          {Coc8, Res8, Done8, Busy8, DivZero8, Ovf8} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_state: w16=%h w8=%h required 0", {Coc, Res, Done, Busy, DivZero, Ovf},
                  {Coc8, Res8, Done8, Busy8, DivZero8, Ovf8});
      end
      @(negedge CLK);
      RSTa = 1'b1;
   endtask

   task automatic test_basic_latency;
      do_op(16'd17, 16'd3, 1'b1);
      n_tests++;
      if (tmo || lat !== 18 || busy_cnt !== 17) begin
         n_fail++;
         $display("FAIL basic_latency: lat=%0d busy=%0d tmo=%0d required lat=18 busy=17", lat, busy_cnt, tmo);
      end
      n_tests++;
      if (Coc !== 16'd5 || Res !== 16'd2 || DivZero !== 1'b0 || Ovf !== 1'b0 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: Coc=%0d Res=%0d dz=%b ovf=%b busy=%b required 5 2 0 0 0", Coc, Res, DivZero, Ovf, Busy);
      end
      release_start();
   endtask

   task automatic test_sign_cases;
      logic [15:0] tn[4] = '{16'(-23), 16'd17, 16'(-17), 16'(-18)};
      logic [15:0] td[4] = '{16'(-5), 16'(-3), 16'd3, 16'd3};
      logic [15:0] tq[4] = '{16'd4, 16'(-5), 16'(-5), 16'(-6)};
      logic [15:0] tr[4] = '{16'(-3), 16'd2, 16'(-2), 16'd0};
      for (int i = 0; i < 4; i++) begin
         do_op(tn[i], td[i], 1'b1);
         n_tests++;
         if (tmo || Coc !== tq[i] || Res !== tr[i]) begin
            n_fail++;
            $display("FAIL sign_case%0d: Coc=%h Res=%h tmo=%0d required %h %h", i, Coc, Res, tmo, tq[i], tr[i]);
         end
         release_start();
      end
   endtask

   task automatic test_mode_contrast;
      do_op(16'hFFFF, 16'd2, 1'b0);
      n_tests++;
      if (tmo || Coc !== 16'h7FFF || Res !== 16'd1) begin
         n_fail++;
         $display("FAIL mode_unsigned: Coc=%h Res=%h required 7fff 0001", Coc, Res);
      end
      release_start();
      do_op(16'hFFFF, 16'd2, 1'b1);
      n_tests++;
      if (tmo || Coc !== 16'h0000 || Res !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL mode_signed: Coc=%h Res=%h required 0000 ffff", Coc, Res);
      end
      release_start();
   endtask

   task automatic test_div_zero;
      do_op(16'd100, 16'd0, 1'b1);
      n_tests++;
      if (tmo || lat !== 1 || busy_cnt !== 0 || DivZero !== 1'b1 || Ovf !== 1'b0 ||
          Coc !== 16'hFFFF || Res !== 16'd100) begin
         n_fail++;
         $display("FAIL div_zero: lat=%0d busy=%0d dz=%b ovf=%b Coc=%h Res=%0d required 1 0 1 0 ffff 100",
                  lat, busy_cnt, DivZero, Ovf, Coc, Res);
      end
      release_start();
      do_op(16'd20, 16'd4, 1'b0);
      n_tests++;
      if (tmo || DivZero !== 1'b0 || Coc !== 16'd5 || Res !== 16'd0) begin
         n_fail++;
         $display("FAIL div_zero_clear: dz=%b Coc=%0d Res=%0d required 0 5 0", DivZero, Coc, Res);
      end
      release_start();
   endtask

   task automatic test_overflow;
      do_op(16'h8000, 16'hFFFF, 1'b1);
      n_tests++;
      if (tmo || Ovf !== 1'b1 || DivZero !== 1'b0 || Coc !== 16'h8000 || Res !== 16'd0) begin
         n_fail++;
         $display("FAIL ovf_signed: ovf=%b dz=%b Coc=%h Res=%h required 1 0 8000 0000", Ovf, DivZero, Coc, Res);
      end
      release_start();
      do_op(16'h8000, 16'hFFFF, 1'b0);
      n_tests++;
      if (tmo || Ovf !== 1'b0 || Coc !== 16'h0000 || Res !== 16'h8000) begin
         n_fail++;
         $display("FAIL ovf_unsigned: ovf=%b Coc=%h Res=%h required 0 0000 8000", Ovf, Coc, Res);
      end
      release_start();
   endtask

   task automatic test_reset_mid_iter;
      @(negedge CLK);
      Num = 16'd1000; Den = 16'd7; Signed_Mode = 1'b0; Start = 1'b1;
      repeat (6) @(posedge CLK);
      #2;
      RSTa = 1'b0; Start = 1'b0;
      #1;
      n_tests++;
      if ({Coc, Res, Done, Busy, DivZero, Ovf} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_mid_iter: outs=%h required 0", {Coc, Res, Done, Busy, DivZero, Ovf});
      end
      @(negedge CLK);
      RSTa = 1'b1;
      do_op(16'd15, 16'd3, 1'b1);
      n_tests++;
      if (tmo || lat !== 18 || Coc !== 16'd5 || Res !== 16'd0) begin
         n_fail++;
         $display("FAIL after_reset: lat=%0d Coc=%0d Res=%0d required 18 5 0", lat, Coc, Res);
      end
      release_start();
   endtask

   task automatic test_hold_start;
      int bad;
      do_op(16'd40, 16'd6, 1'b0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         if (Done !== 1'b1 || Busy !== 1'b0 || Coc !== 16'd6 || Res !== 16'd4) bad++;
      end
      n_tests++;
      if (tmo || bad != 0) begin
         n_fail++;
         $display("FAIL hold_start: bad_cycles=%0d tmo=%0d required 0", bad, tmo);
      end
      release_start();
      @(posedge CLK); #1;
      n_tests++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: Done=%b Busy=%b required 0 0", Done, Busy);
      end
   endtask

   task automatic test_width8;
      int l8;
      @(negedge CLK);
      Num8 = 8'd17; Den8 = 8'd3; Smode8 = 1'b1; Start8 = 1'b1;
      @(posedge CLK); #1;
      l8 = 0;
      do begin
         @(posedge CLK); #1;
         l8++;
      end while (!Done8 && l8 < 40);
      n_tests++;
      if (Done8 !== 1'b1 || l8 !== 10 || Coc8 !== 8'd5 || Res8 !== 8'd2) begin
         n_fail++;
         $display("FAIL width8: lat=%0d Coc=%0d Res=%0d Done=%b required 10 5 2 1", l8, Coc8, Res8, Done8);
      end
      @(negedge CLK);
      Start8 = 1'b0;
   endtask

   task automatic test_random;
      logic [15:0] n, d, eq, er;
      bit sm, edz, eovf;
      int sel, elat;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         sm  = 1'($urandom);
         n   = 16'($urandom);
         d   = (sel < 4) ? 16'($urandom_range(1, 40)) : 16'($urandom);
         if (sel < 4 && sm && $urandom_range(0, 1) == 1) d = 16'(-int'(d));
         if (sel == 8) d = 16'd0;
         if (sel == 9) begin n = 16'h8000; d = 16'hFFFF; end
         ref_div(16, n, d, sm, eq, er, edz, eovf);
         elat = edz ? 1 : 18;
         do_op(n, d, sm);
         n_tests++;
         if (tmo || lat !== elat || Coc !== eq || Res !== er || DivZero !== edz || Ovf !== eovf) begin
            n_fail++;
            $display("FAIL random%0d n=%h d=%h s=%0d: got q=%h r=%h dz=%b ovf=%b lat=%0d required q=%h r=%h dz=%b ovf=%b lat=%0d",
                     i, n, d, sm, Coc, Res, DivZero, Ovf, lat, eq, er, edz, eovf, elat);
         end
         release_start();
      end
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_sign_cases();
      test_mode_contrast();
      test_div_zero();
      test_overflow();
      test_reset_mid_iter();
      test_hold_start();
      test_width8();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
